// File: rtl/result_stream_tx_if.sv
// Stream bundle between the accumulator stage, result_stream_tx and the S2MM DMA.
// Tile side: in_data/in_valid from the accumulators, in_ready back to them.
// Row side:  out_data/out_valid/out_last to the DMA, out_ready back from it.
// master: the environment (accumulator producer + DMA consumer).
// slave:  the transmit block itself.
interface result_stream_tx_if #(
    parameter int unsigned O_DIM  = 10,
    parameter int unsigned M_BITS = 16
);
    logic [O_DIM-1:0][O_DIM-1:0][M_BITS-1:0] in_data;
    logic                                    in_valid;
    logic                                    in_ready;
    logic [O_DIM-1:0][M_BITS-1:0]            out_data;
    logic                                    out_valid;
    logic                                    out_ready;
    logic                                    out_last;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  out_data,
        input  out_valid,
        output out_ready,
        input  out_last
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output out_data,
        output out_valid,
        input  out_ready,
        output out_last
    );
endinterface

// File: rtl/result_stream_tx.sv
// Captures one O_DIM x O_DIM result tile in a single handshake and streams it
// to the DMA as O_DIM row beats (out_last on the final row).
// Ports:
//   clk           clock
//   rstn          synchronous active-low reset
//   bus           result_stream_tx_if.slave (tile in, row beats out)
//   tiles_sent_o  count of completed tiles, wraps modulo 2^CNT_BITS
module result_stream_tx #(
    parameter int unsigned K_DIM    = 3,
    parameter int unsigned I_DIM    = 8,
    parameter int unsigned M_BITS   = 16,
    parameter int unsigned O_DIM    = K_DIM + I_DIM - 1,
    parameter int unsigned CNT_BITS = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    result_stream_tx_if.slave    bus,
    output logic [CNT_BITS-1:0]  tiles_sent_o
);
    localparam int unsigned O_BITS = $clog2(O_DIM + 1);
    localparam logic [O_BITS-1:0] LAST_ROW = O_BITS'(O_DIM - 1);

    typedef logic [O_DIM-1:0][M_BITS-1:0] row_t;
    typedef logic [O_DIM-1:0][O_DIM-1:0][M_BITS-1:0] tile_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1
    } state_e;

    state_e              state_q, state_d;
    logic [O_BITS-1:0]   row_q, row_d;
    logic [O_BITS-1:0]   row_nxt;
    tile_t               buf_q, buf_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic                out_last_q, out_last_d;
    row_t                out_data_q, out_data_d;
    logic                in_fire;
    logic                out_fire;

    assign in_fire  = bus.in_valid && in_ready_q;
    assign out_fire = out_valid_q && bus.out_ready;
    assign row_nxt  = row_q + O_BITS'(1);

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            row_q       <= '0;
            buf_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            buf_q       <= buf_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
        end
    end

    // Next-state logic; outputs are precomputed for the next cycle so that
    // out_data always equals buf[row] while a beat is presented.
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        buf_d       = buf_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;

        case (state_q)
            IDLE: begin
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
                if (in_fire) begin
                    buf_d       = bus.in_data;
                    row_d       = '0;
                    state_d     = SEND;
                    in_ready_d  = 1'b0;
                    out_valid_d = 1'b1;
                    out_data_d  = bus.in_data[0];
                    out_last_d  = (LAST_ROW == O_BITS'(0));
                end
            end
            SEND: begin
                if (out_fire) begin
                    if (row_q == LAST_ROW) begin
                        row_d       = '0;
                        cnt_d       = cnt_q + CNT_BITS'(1);
                        state_d     = IDLE;
                        in_ready_d  = 1'b1;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                    end else begin
                        row_d       = row_nxt;
                        out_data_d  = buf_q[row_nxt];
                        out_last_d  = (row_nxt == LAST_ROW);
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                row_d       = '0;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
            end
        endcase
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_data  = out_data_q;
    assign tiles_sent_o  = cnt_q;
endmodule
